// File: rtl/cpu_pkg.sv
// Shared CPU front-end types.
//   fetch_state_t : fetch FSM states (REQ / WAIT / DROP)
//   fetch_entry_t : one buffered fetch, {pc, inst}
//   RESET_PC_DEFAULT, INST_BYTES : fetch defaults
package cpu_pkg;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'd100;
  localparam int          INST_BYTES       = 4;

  // REQ : nothing outstanding
  // WAIT: one fetch outstanding, its response will be queued
  // DROP: one fetch outstanding, its response is stale (post-redirect)
  typedef enum logic [1:0] {REQ, WAIT, DROP} fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory handshake, decode handshake
// and redirect.
//   master : the fetch unit (drives imem_req/imem_addr and if_*)
//   slave  : memory + decode side (drives responses, stall, redirect)
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;

  modport master (
    output imem_req, imem_addr, if_valid, if_inst, if_pc,
    input  imem_rvalid, imem_rdata, id_stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_inst, if_pc,
    output imem_rvalid, imem_rdata, id_stall, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// Circular instruction buffer between instruction memory and decode.
//   clk, rst   : clock, async active-high reset
//   flush      : drop all entries (wins over push/pop)
//   push/data  : enqueue one fetch_entry_t
//   pop        : dequeue head
//   head       : current head entry (meaningless when empty)
//   count      : occupancy 0..DEPTH
//   full/empty : occupancy flags
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  output fetch_entry_t  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;

  // DEPTH is a power of two, so pointer overflow is the wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // storage needs no reset: count gates visibility
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one-outstanding word
// fetches, buffers responses and hands {pc, inst} to decode.
//   clk, rst : clock, async active-high reset
//   bus      : fetch_unit_if.master
//              imem_req/imem_addr  -> fetch request (pulse per fetch)
//              imem_rvalid/rdata   <- fetch response
//              id_stall            <- decode hold
//              redirect/_pc        <- restart fetch, flush everything
//              if_valid/inst/pc    -> queue head (zeroed when empty)
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t  state;
  logic [31:0]   fetch_pc;
  fetch_entry_t  q_head, rsp_entry;
  logic [CW-1:0] q_count, occ_next;
  logic          q_full, q_empty;
  logic          rsp_hit, push, pop, issue;

  // rvalid only means something while a kept fetch is outstanding
  assign rsp_hit = (state == WAIT) && bus.imem_rvalid;
  // full guard is redundant with the issue rule; it keeps a stray
  // response from overwriting the head
  assign push    = rsp_hit && !bus.redirect && !q_full;
  assign pop     = !q_empty && !bus.id_stall;

  // occupancy after this edge; issue only if the reply will have a slot
  assign occ_next = q_count - CW'(pop) + CW'(push);
  assign issue    = !rst && !bus.redirect && (occ_next < CW'(DEPTH)) &&
                    ((state == REQ) || rsp_hit);

  // fetch_pc already advanced past the outstanding fetch, and nothing
  // else moves it while in WAIT, so the reply belongs to fetch_pc - 4
  assign rsp_entry.pc   = fetch_pc - 32'(INST_BYTES);
  assign rsp_entry.inst = bus.imem_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= REQ;
      fetch_pc <= RESET_PC;
    end else if (bus.redirect) begin
      fetch_pc <= bus.redirect_pc & ~32'h3;
      state    <= (state != REQ && !bus.imem_rvalid) ? DROP : REQ;
    end else if (issue) begin
      fetch_pc <= fetch_pc + 32'(INST_BYTES);
      state    <= WAIT;
    end else if (state != REQ && bus.imem_rvalid) begin
      state    <= REQ;
    end
  end

  fetch_queue #(.DEPTH(DEPTH)) u_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.redirect),
    .push      (push),
    .push_data (rsp_entry),
    .pop       (pop),
    .head      (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign bus.imem_req  = issue;
  assign bus.imem_addr = fetch_pc;
  assign bus.if_valid  = !q_empty;
  assign bus.if_pc     = q_empty ? 32'd0 : q_head.pc;
  assign bus.if_inst   = q_empty ? 32'd0 : q_head.inst;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(32'd100), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int lat    = 1;
  int pend   = 0;
  logic [31:0] pend_addr = 32'd0;
  fetch_entry_t sb[$];

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'd100) return 32'h8C220000;
    if (a == 32'd104) return 32'h8C230004;
    return a ^ 32'hA5A50000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_push(input logic [31:0] pc);
    fetch_entry_t e;
    e.pc   = pc;
    e.inst = mem_data(pc);
    sb.push_back(e);
  endtask

  // instruction memory: replies lat cycles after a sampled request
  initial begin
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'd0;
    forever begin
      @(posedge clk); #1;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'd0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = mem_data(pend_addr);
        end
      end
      @(negedge clk);
      if (bus.imem_req === 1'b1) begin
        pend      = lat;
        pend_addr = bus.imem_addr;
      end
    end
  end

  // scoreboard: each instruction consumed by decode is popped and compared
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.if_valid === 1'b1 && bus.id_stall === 1'b0 && bus.redirect === 1'b0) begin
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL sb_extra: got pc %h, expected nothing", bus.if_pc);
        end else begin
          fetch_entry_t e;
          e = sb.pop_front();
          chk("sb_pc", bus.if_pc, e.pc);
          chk("sb_inst", bus.if_inst, e.inst);
        end
      end
      if (!rst && dut.q_full) begin
        n_chk++;
        if (dut.rsp_hit && !bus.redirect) begin
          n_fail++;
          $display("FAIL q_overflow: got push into full queue, expected none");
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  // assert reset, check reset outputs, release into cycle 1 input phase
  task automatic do_reset(input int l);
    @(posedge clk); #1;
    rst             = 1'b1;
    bus.id_stall    = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'd0;
    lat             = l;
    #1;
    chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
    chk("rst_if_pc",    bus.if_pc,   32'd0);
    chk("rst_if_inst",  bus.if_inst, 32'd0);
    chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
    chk("rst_imem_addr", bus.imem_addr, 32'd100);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    sb.delete();
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  typedef struct {
    logic        stall;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } vec_t;

  vec_t tv[11];

  initial begin
    logic        er, ev;
    logic [31:0] ea;

    tv[0]  = '{1'b0, 1'b1, 32'd100, 1'b0, 32'd0};
    tv[1]  = '{1'b0, 1'b1, 32'd104, 1'b0, 32'd0};
    tv[2]  = '{1'b1, 1'b0, 32'd108, 1'b1, 32'd100};
    tv[3]  = '{1'b1, 1'b0, 32'd108, 1'b1, 32'd100};
    tv[4]  = '{1'b1, 1'b0, 32'd108, 1'b1, 32'd100};
    tv[5]  = '{1'b1, 1'b0, 32'd108, 1'b1, 32'd100};
    tv[6]  = '{1'b1, 1'b0, 32'd108, 1'b1, 32'd100};
    tv[7]  = '{1'b0, 1'b1, 32'd108, 1'b1, 32'd100};
    tv[8]  = '{1'b0, 1'b1, 32'd112, 1'b1, 32'd104};
    tv[9]  = '{1'b0, 1'b1, 32'd116, 1'b1, 32'd108};
    tv[10] = '{1'b0, 1'b1, 32'd120, 1'b1, 32'd112};

    // L=1 streaming with a 5-cycle stall after the first valid
    do_reset(1);
    sb_push(32'd100); sb_push(32'd104); sb_push(32'd108); sb_push(32'd112);
    for (int i = 0; i < 11; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      bus.id_stall = tv[i].stall;
      @(negedge clk);
      chk($sformatf("t1_req_c%0d", i + 1),   32'(bus.imem_req), 32'(tv[i].req));
      chk($sformatf("t1_addr_c%0d", i + 1),  bus.imem_addr,     tv[i].addr);
      chk($sformatf("t1_valid_c%0d", i + 1), 32'(bus.if_valid), 32'(tv[i].valid));
      chk($sformatf("t1_pc_c%0d", i + 1),    bus.if_pc,         tv[i].pc);
    end

    // L=3, redirect to 0x200 while the fetch to 108 is outstanding
    do_reset(3);
    sb_push(32'd100); sb_push(32'd104); sb_push(32'h200);
    for (int c = 1; c <= 15; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      bus.redirect    = (c == 9);
      bus.redirect_pc = 32'h200;
      er = (c == 1 || c == 4 || c == 7 || c == 11 || c == 14);
      ea = (c == 1) ? 32'd100 : (c == 4) ? 32'd104 : (c == 7) ? 32'd108 :
           (c == 11) ? 32'h200 : 32'h204;
      ev = (c == 5 || c == 8 || c == 15);
      @(negedge clk);
      chk($sformatf("t2_req_c%0d", c), 32'(bus.imem_req), 32'(er));
      if (er) chk($sformatf("t2_addr_c%0d", c), bus.imem_addr, ea);
      chk($sformatf("t2_valid_c%0d", c), 32'(bus.if_valid), 32'(ev));
    end

    // redirect coinciding with a response while decode stalls
    do_reset(1);
    sb_push(32'h300); sb_push(32'h304);
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      bus.id_stall    = (c <= 3);
      bus.redirect    = (c == 3);
      bus.redirect_pc = 32'h301;
      @(negedge clk);
      case (c)
        3: begin
          chk("t3_rvalid_in_redirect", 32'(bus.imem_rvalid), 32'd1);
          chk("t3_req_redirect", 32'(bus.imem_req), 32'd0);
        end
        4: begin
          chk("t3_valid_after", 32'(bus.if_valid), 32'd0);
          chk("t3_req_after", 32'(bus.imem_req), 32'd1);
          chk("t3_addr_after", bus.imem_addr, 32'h300);
        end
        5: chk("t3_addr_next", bus.imem_addr, 32'h304);
        default: ;
      endcase
    end

    // async reset mid-fetch, stale reply ignored, then PC wrap
    do_reset(3);
    sb_push(32'd100); sb_push(32'hFFFFFFFC); sb_push(32'd0);
    bus.id_stall = 1'b1;
    @(negedge clk);
    chk("t4_req_c1", 32'(bus.imem_req), 32'd1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("t4_valid_c5", 32'(bus.if_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t4_async_valid", 32'(bus.if_valid), 32'd0);
    chk("t4_async_pc",    bus.if_pc,   32'd0);
    chk("t4_async_inst",  bus.if_inst, 32'd0);
    chk("t4_async_req",   32'(bus.imem_req), 32'd0);
    chk("t4_async_addr",  bus.imem_addr, 32'd100);
    @(posedge clk);
    @(posedge clk); #1;
    rst          = 1'b0;
    bus.id_stall = 1'b0;
    for (int c = 7; c <= 21; c++) begin
      if (c > 7) begin @(posedge clk); #1; end
      bus.redirect    = (c == 12);
      bus.redirect_pc = 32'hFFFFFFFD;
      @(negedge clk);
      case (c)
        7: begin
          chk("t4_stale_rvalid", 32'(bus.imem_rvalid), 32'd1);
          chk("t4_req_c7", 32'(bus.imem_req), 32'd1);
          chk("t4_addr_c7", bus.imem_addr, 32'd100);
        end
        8:  chk("t4_valid_c8", 32'(bus.if_valid), 32'd0);
        12: chk("t4_req_c12", 32'(bus.imem_req), 32'd0);
        13: begin
          chk("t4_req_c13", 32'(bus.imem_req), 32'd0);
          chk("t4_valid_c13", 32'(bus.if_valid), 32'd0);
        end
        14: begin
          chk("t4_req_c14", 32'(bus.imem_req), 32'd1);
          chk("t4_addr_c14", bus.imem_addr, 32'hFFFFFFFC);
        end
        17: begin
          chk("t4_req_wrap", 32'(bus.imem_req), 32'd1);
          chk("t4_addr_wrap", bus.imem_addr, 32'd0);
        end
        default: ;
      endcase
    end

    do_reset(1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
